knn_ctrl: RTL and testbench

Batch sequencer for the `knn` multi-solver datapath. It loads one test point into each of the N_SOLVERS solver slots through `SOLVER_SEL`/`DATA_1`. It then broadcasts a stream of training points on `DATA_2`/`valid` to all solvers, pulses `DONE`, and waits for the sorter pipelines to settle. Finally it walks `SOLVER_SEL`/`SEL` to read the HW_K nearest-neighbour entries of every solver and presents them on a ready/valid result stream. It sits between the CPU-facing register/stream interface and `knn`.

---
 rtl/knn_ctrl_pkg.sv | 37 +++
 rtl/knn_ctrl_rd_seq.sv | 42 ++++
 rtl/knn_ctrl.sv | 168 ++++++++++++++++
 tb/tb_knn_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/knn_ctrl_pkg.sv
// Shared definitions for the knn batch sequencer: FSM states, slot park value
// and the {y, x} point field split also used by the knn datapath.
package knn_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE_P,
        ST_FLUSH,
        ST_RD_SET,
        ST_RD_CAP,
        ST_RD_OUT
    } state_t;

    localparam int SEL_W = 16;
    localparam int X_LSB = 0;

    function automatic int x_msb(input int w);
        return w / 2 - 1;
    endfunction

    function automatic int y_lsb(input int w);
        return w / 2;
    endfunction

    function automatic int y_msb(input int w);
        return w - 1;
    endfunction

    // One past the last slot, so knn never matches it and no slot is overwritten.
    function automatic int park_value(input int n_solvers);
        return n_solvers;
    endfunction

endpackage

// File: rtl/knn_ctrl_rd_seq.sv
// Nested rank/slot counter for the readout phase; rank wraps at HW_K and
// advances the slot, last flags the final (N_SOLVERS-1, HW_K-1) entry.
module knn_ctrl_rd_seq #(
    parameter int SW        = 16,
    parameter int HW_K      = 10,
    parameter int N_SOLVERS = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          advance,
    output logic [SW-1:0] slot,
    output logic [15:0]   rank,
    output logic          last
);

    logic wrap;

    assign wrap = (rank == 16'(HW_K - 1));
    assign last = wrap && (slot == SW'(N_SOLVERS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot <= '0;
            rank <= '0;
        end else if (clear) begin
            slot <= '0;
            rank <= '0;
        end else if (advance) begin
            if (last) begin
                slot <= '0;
                rank <= '0;
            end else if (wrap) begin
                slot <= slot + SW'(1);
                rank <= '0;
            end else begin
                rank <= rank + 16'd1;
            end
        end
    end

endmodule

// File: rtl/knn_ctrl.sv
// Batch sequencer for the knn multi-solver datapath: load, stream, flush, read out.
// Optional feature: define KNN_CTRL_PERF_EN to build the saturating batch cycle counter.
module knn_ctrl
    import knn_ctrl_pkg::*;
#(
    parameter int W         = 32,
    parameter int HW_K      = 10,
    parameter int N_SOLVERS = 2,
    parameter int CNT_W     = 16,
    parameter int FLUSH_LAT = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CNT_W-1:0]   n_train,
    input  logic               test_valid,
    output logic               test_ready,
    input  logic [W-1:0]       test_data,
    input  logic               train_valid,
    output logic               train_ready,
    input  logic [W-1:0]       train_data,
    output logic [W/2-1:0]     SOLVER_SEL,
    output logic [W-1:0]       DATA_1,
    output logic [W-1:0]       DATA_2,
    output logic               valid,
    output logic               DONE,
    output logic [SEL_W-1:0]   SEL,
    input  logic [W/2-1:0]     DATA_OUT,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [W/2-1:0]     res_data,
    output logic [W/2-1:0]     res_solver,
    output logic [SEL_W-1:0]   res_idx,
    output logic               busy,
    output logic [31:0]        perf_cycles
);

    localparam int SW = W / 2;
    localparam logic [SW-1:0]    PARK       = SW'(park_value(N_SOLVERS));
    localparam logic [SW-1:0]    LAST_SLOT  = SW'(N_SOLVERS - 1);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_LAT - 1);

    state_t            state, state_next;
    logic [CNT_W-1:0]  n_lat, train_cnt, flush_cnt;
    logic [CNT_W:0]    train_cnt_p1;
    logic [SW-1:0]     load_slot, rd_slot;
    logic [15:0]       rd_rank;
    logic              rd_last;
    logic              test_hs, train_hs, res_hs;
    logic              load_last, train_last, flush_last;

    assign test_hs      = (state == ST_LOAD) && test_valid && test_ready;
    assign train_hs     = (state == ST_STREAM) && train_valid && train_ready;
    assign res_hs       = (state == ST_RD_OUT) && res_valid && res_ready;
    assign load_last    = (load_slot == LAST_SLOT);
    assign train_cnt_p1 = {1'b0, train_cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign train_last   = (train_cnt_p1 == {1'b0, n_lat});
    assign flush_last   = (flush_cnt == FLUSH_LAST);

    knn_ctrl_rd_seq #(
        .SW        (SW),
        .HW_K      (HW_K),
        .N_SOLVERS (N_SOLVERS)
    ) u_rd_seq (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == ST_DONE_P),
        .advance (res_hs),
        .slot    (rd_slot),
        .rank    (rd_rank),
        .last    (rd_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:   if (start) state_next = ST_LOAD;
            // load_slot reaches the park value one cycle after the last handshake,
            // giving knn the cycle it needs to load the final slot.
            ST_LOAD:   if (load_slot == PARK)
                           state_next = (n_lat == '0) ? ST_DRAIN : ST_STREAM;
            ST_STREAM: if (train_hs && train_last) state_next = ST_DRAIN;
            ST_DRAIN:  state_next = ST_DONE_P;
            ST_DONE_P: state_next = ST_FLUSH;
            ST_FLUSH:  if (flush_last) state_next = ST_RD_SET;
            ST_RD_SET: state_next = ST_RD_CAP;
            ST_RD_CAP: state_next = ST_RD_OUT;
            ST_RD_OUT: if (res_hs) state_next = rd_last ? ST_IDLE : ST_RD_SET;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy        <= 1'b0;
            test_ready  <= 1'b0;
            train_ready <= 1'b0;
            valid       <= 1'b0;
            DONE        <= 1'b0;
            SOLVER_SEL  <= PARK;
            SEL         <= '0;
            DATA_1      <= '0;
            DATA_2      <= '0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_solver  <= '0;
            res_idx     <= '0;
            n_lat       <= '0;
            train_cnt   <= '0;
            flush_cnt   <= '0;
            load_slot   <= '0;
        end else begin
            busy        <= (state_next != ST_IDLE);
            test_ready  <= (state == ST_IDLE && start) || (test_ready && !(test_hs && load_last));
            train_ready <= (state == ST_STREAM) && !(train_hs && train_last);
            valid       <= train_hs;
            DONE        <= (state == ST_DRAIN);
            if (state == ST_IDLE && start) begin
                n_lat     <= n_train;
                train_cnt <= '0;
                flush_cnt <= '0;
                load_slot <= '0;
            end
            if (test_hs) begin
                DATA_1     <= test_data;
                SOLVER_SEL <= load_slot;
                load_slot  <= load_slot + SW'(1);
            end else if (state == ST_LOAD && load_slot == PARK) begin
                SOLVER_SEL <= PARK;
            end
            if (train_hs) begin
                DATA_2    <= train_data;
                train_cnt <= train_cnt + CNT_W'(1);
            end
            if (state == ST_FLUSH) flush_cnt <= flush_cnt + CNT_W'(1);
            if (state == ST_RD_SET) begin
                SOLVER_SEL <= rd_slot;
                SEL        <= rd_rank;
            end
            if (state == ST_RD_CAP) begin
                res_data   <= DATA_OUT;
                res_solver <= rd_slot;
                res_idx    <= rd_rank;
                res_valid  <= 1'b1;
            end
            if (res_hs) begin
                res_valid <= 1'b0;
                if (rd_last) SOLVER_SEL <= PARK;
            end
        end
    end

`ifdef KNN_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                  perf_cycles <= '0;
        else if (state == ST_IDLE && start)        perf_cycles <= '0;
        else if (state != ST_IDLE && perf_cycles != '1) perf_cycles <= perf_cycles + 32'd1;
    end
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_knn_ctrl.sv
// Scoreboard bench for knn_ctrl with a behavioural knn model; results and training
// points are queued by the stimulus and checked by an independent negedge monitor.
module tb_knn_ctrl;

    localparam int W     = 32;
    localparam int HW_K  = 10;
    localparam int NS    = 2;
    localparam int CNT_W = 16;
    localparam int FL    = 12;

    typedef struct packed {
        logic [15:0] solver;
        logic [15:0] idx;
        logic [15:0] data;
    } res_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start, test_valid, test_ready, train_valid, train_ready;
    logic [CNT_W-1:0] n_train;
    logic [W-1:0]     test_data, train_data, DATA_1, DATA_2;
    logic [15:0]      SOLVER_SEL, SEL, DATA_OUT, res_data, res_solver, res_idx;
    logic             valid, DONE, res_valid, res_ready, busy;
    logic [31:0]      perf_cycles;

    knn_ctrl #(
        .W(W), .HW_K(HW_K), .N_SOLVERS(NS), .CNT_W(CNT_W), .FLUSH_LAT(FL)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .n_train(n_train),
        .test_valid(test_valid), .test_ready(test_ready), .test_data(test_data),
        .train_valid(train_valid), .train_ready(train_ready), .train_data(train_data),
        .SOLVER_SEL(SOLVER_SEL), .DATA_1(DATA_1), .DATA_2(DATA_2), .valid(valid),
        .DONE(DONE), .SEL(SEL), .DATA_OUT(DATA_OUT),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_solver(res_solver), .res_idx(res_idx), .busy(busy), .perf_cycles(perf_cycles)
    );

    always #5 clk = ~clk;

    // knn model: neighbour entry is a fixed function of (slot, rank).
    assign DATA_OUT = 16'hA000 + {SOLVER_SEL[7:0], 8'h00} + SEL;

    int          vectors = 0;
    int          miscompares = 0;
    res_t        exp_q[$];
    logic [31:0] train_q[$];
    logic [31:0] exp_tp[NS];
    logic [31:0] slot_mem[NS];
    int          batch_n, valid_cnt, done_cnt, stall_seen, cyc, last_valid_cyc;
    int          stall_s, stall_r, stall_left;
    bit          stall_done, held_v, have_last;
    logic [31:0] last_train;
    res_t        held, cur, mon_e;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            held_v     = 0;
            have_last  = 0;
            stall_left = 0;
            res_ready  = 1'b1;
        end else begin
            if (valid) begin
                valid_cnt++;
                last_valid_cyc = cyc;
                if (train_q.size() == 0) checkOutput("extra_valid", 1, 0);
                else                     checkOutput("data_2", DATA_2, train_q.pop_front());
                last_train = DATA_2;
                have_last  = 1;
            end else if (have_last) begin
                checkOutput("data_2_hold", DATA_2, last_train);
            end
            if (SOLVER_SEL < 16'(NS)) slot_mem[int'(SOLVER_SEL)] = DATA_1;
            if (train_ready || !busy) checkOutput("sel_parked", SOLVER_SEL, NS);
            if (DONE) begin
                done_cnt++;
                if (batch_n > 0) checkOutput("done_after_drain", cyc - last_valid_cyc, 1);
                for (int s = 0; s < NS; s++) checkOutput("slot_load", slot_mem[s], exp_tp[s]);
            end
            if (res_valid && !stall_done && res_solver == 16'(stall_s) && res_idx == 16'(stall_r)) begin
                stall_done = 1;
                stall_left = 5;
            end
            if (stall_left > 0) begin
                res_ready = 1'b0;
                stall_left--;
            end else begin
                res_ready = 1'b1;
            end
            if (res_valid && !res_ready) stall_seen++;
            cur = '{solver: res_solver, idx: res_idx, data: res_data};
            if (res_valid && held_v) checkOutput("res_hold", cur, held);
            held_v = res_valid && !res_ready;
            held   = cur;
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("extra_result", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    checkOutput("res_solver", res_solver, mon_e.solver);
                    checkOutput("res_idx", res_idx, mon_e.idx);
                    checkOutput("res_data", res_data, mon_e.data);
                end
            end
        end
    end

    task automatic waitReady(input bit train);
        bit ok = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (train ? train_ready : test_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) checkOutput("ready_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int b, input int n, input bit gaps,
                                 input int st_s, input int st_r, input int abort_at);
        bit done_ok = 0;
        exp_q.delete();
        train_q.delete();
        valid_cnt = 0; done_cnt = 0; stall_seen = 0; batch_n = n;
        stall_s = st_s; stall_r = st_r; stall_done = 0; last_valid_cyc = -100;
        for (int s = 0; s < NS; s++) begin
            exp_tp[s]   = 32'h1000_0000 * 32'(b + 1) + 32'h0001_0001 * 32'(s + 3);
            slot_mem[s] = '0;
            for (int r = 0; r < HW_K; r++)
                exp_q.push_back('{solver: 16'(s), idx: 16'(r), data: 16'hA000 + 16'(s * 256 + r)});
        end
        @(posedge clk); #1;
        start = 1'b1; n_train = 16'(n);
        @(posedge clk); #1;
        start = 1'b0;
        for (int s = 0; s < NS; s++) begin
            test_data  = exp_tp[s];
            test_valid = 1'b1;
            waitReady(0);
        end
        test_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i == abort_at) begin
                train_valid = 1'b0;
                @(posedge clk); #3;
                rst = 1'b0;
                #1;
                checkOutput("abort_busy", busy, 0);
                checkOutput("abort_sel", SOLVER_SEL, NS);
                checkOutput("abort_train_ready", train_ready, 0);
                checkOutput("abort_valid", valid, 0);
                checkOutput("abort_done", DONE, 0);
                checkOutput("abort_res_valid", res_valid, 0);
                repeat (2) @(posedge clk);
                @(negedge clk); #1;
                rst = 1'b1;
                exp_q.delete();
                train_q.delete();
                return;
            end
            if (gaps && (i % 2 == 1)) begin
                train_valid = 1'b0;
                start = 1'b1; n_train = 16'd9;
                repeat (2) @(posedge clk);
                #1;
                start = 1'b0;
            end
            train_data = 32'hC000_0000 + 32'(b * 256 + i);
            train_q.push_back(train_data);
            train_valid = 1'b1;
            waitReady(1);
        end
        train_data = 32'hDEAD_BEEF;
        train_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        train_valid = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (!busy) begin
                done_ok = 1;
                break;
            end
        end
        if (!done_ok) checkOutput("batch_timeout", 0, 1);
        checkOutput("results_left", exp_q.size(), 0);
        checkOutput("train_left", train_q.size(), 0);
        checkOutput("done_count", done_cnt, 1);
        checkOutput("valid_count", valid_cnt, n);
        if (st_s >= 0) checkOutput("stall_cycles", stall_seen, 5);
        checkOutput("end_res_valid", res_valid, 0);
    endtask

    task automatic checkPerf(input int n);
`ifdef KNN_CTRL_PERF_EN
        checkOutput("perf_cycles", perf_cycles, 2 + NS + n + 2 + FL + 3 * NS * HW_K);
`else
        checkOutput("perf_cycles", perf_cycles, 0);
`endif
    endtask

    initial begin
        start = 0; n_train = '0; test_valid = 0; test_data = '0;
        train_valid = 0; train_data = '0; res_ready = 1'b1;
        #1 rst = 1'b0;
        #2;
        checkOutput("rst_sel", SOLVER_SEL, NS);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_test_ready", test_ready, 0);
        checkOutput("rst_train_ready", train_ready, 0);
        checkOutput("rst_valid", valid, 0);
        checkOutput("rst_done", DONE, 0);
        checkOutput("rst_res_valid", res_valid, 0);
        checkOutput("rst_data_2", DATA_2, 0);
        checkOutput("rst_perf", perf_cycles, 0);
        @(negedge clk);
        rst = 1'b1;

        applyStimulus(0, 4, 0, -1, -1, -1);
        checkPerf(4);
        applyStimulus(1, 0, 0, -1, -1, -1);
        applyStimulus(2, 4, 1, -1, -1, -1);
        applyStimulus(3, 3, 0, 0, 3, -1);
        applyStimulus(4, 4, 0, -1, -1, 2);
        applyStimulus(5, 4, 0, -1, -1, -1);
        checkPerf(4);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
